// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: chooses the next PC, runs the IM ready handshake,
// buffers the fetched word while D stalls and defers a taken branch past its delay slot.
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_LO     = 32'h0000_3000,
  parameter logic [31:0] PC_HI     = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        im_ready_i,
  input  logic [31:0] im_instr_i,
  output logic        im_req_o,
  output logic        pc_we_o,
  output logic [31:0] npc_o,
  output logic        f_valid_o,
  output logic [31:0] f_instr_o,
  output logic        f_adel_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        pend_v, pend_v_nxt;
  logic [31:0] pend_addr, pend_addr_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;

  logic        bad;
  logic        redirect;
  logic        done;
  logic [31:0] fetch_word;
  logic [31:0] pc_inc;
  logic [31:0] npc_sel;

  assign bad      = (pc_i[1:0] != 2'b00) || (pc_i < PC_LO) || (pc_i > PC_HI);
  assign pc_inc   = pc_i + 32'd4;
  assign redirect = (state != IDLE) && (req_i || eret_i);

  // A deferred branch outranks a fresh one: it belongs to an older instruction.
  always_comb begin
    npc_sel = pc_inc;
    if (req_i)           npc_sel = EXC_ENTRY;
    else if (eret_i)     npc_sel = epc_i;
    else if (pend_v)     npc_sel = pend_addr;
    else if (br_taken_i) npc_sel = br_target_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      buf_instr <= '0;
    end else begin
      state     <= state_nxt;
      pend_v    <= pend_v_nxt;
      pend_addr <= pend_addr_nxt;
      buf_instr <= buf_instr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_v_nxt    = pend_v;
    pend_addr_nxt = pend_addr;
    buf_instr_nxt = buf_instr;
    im_req_o      = 1'b0;
    pc_we_o       = 1'b0;
    npc_o         = npc_sel;
    f_valid_o     = 1'b0;
    f_instr_o     = '0;
    f_adel_o      = 1'b0;
    done          = 1'b0;
    fetch_word    = bad ? 32'd0 : im_instr_i;

    if (redirect) begin
      // Any in-flight IM access is simply dropped; the new PC restarts it.
      pc_we_o    = 1'b1;
      pend_v_nxt = 1'b0;
      state_nxt  = FETCH;
    end else begin
      case (state)
        IDLE: begin
          npc_o     = '0;
          state_nxt = FETCH;
        end
        FETCH: begin
          im_req_o  = !bad;
          done      = bad || im_ready_i;
          f_instr_o = fetch_word;
          if (done) begin
            f_valid_o = 1'b1;
            f_adel_o  = bad;
            if (stall_i) begin
              buf_instr_nxt = fetch_word;
              state_nxt     = HOLD;
            end else begin
              pc_we_o    = 1'b1;
              pend_v_nxt = 1'b0;
            end
          end
        end
        HOLD: begin
          f_valid_o = 1'b1;
          f_instr_o = buf_instr;
          f_adel_o  = bad;
          if (!stall_i) begin
            pc_we_o    = 1'b1;
            pend_v_nxt = 1'b0;
            state_nxt  = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Without a PC write this cycle the delay slot is still outstanding, so park the target.
    if (br_taken_i && !pc_we_o && !redirect) begin
      pend_v_nxt    = 1'b1;
      pend_addr_nxt = br_target_i;
    end

    if (!reset) begin
      im_req_o  = 1'b0;
      pc_we_o   = 1'b0;
      f_valid_o = 1'b0;
      f_instr_o = '0;
      f_adel_o  = 1'b0;
      npc_o     = RESET_PC;
    end
  end

endmodule

// File: doc/f_fetch_ctrl.md
Name: f_fetch_ctrl

Overview:
- Fetch-stage sequencer for the F-stage PC register and instruction memory in the pipelined MIPS core.
- Each cycle it decides the next PC and the PC write enable, and drives the IM request with a ready handshake.
- It holds a fetched instruction in a one-entry buffer while D is stalled.
- It defers a D-stage branch redirect until the delay-slot fetch completes.
- It applies exception-entry and eret redirects with fixed priority and flags fetch address errors.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset; must match the PC register reset value.
EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry address.
PC_LO, 32'h0000_3000, lowest legal fetch address.
PC_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
pc_i  in  32  current PC from the F-stage PC register.
stall_i  in  1  D-stage stall from the hazard unit.
req_i  in  1  exception/interrupt entry request from CP0; highest priority.
eret_i  in  1  eret commit.
epc_i  in  32  return address, valid with eret_i.
br_taken_i  in  1  one-cycle pulse: D-stage branch/jump taken.
br_target_i  in  32  branch target, valid with br_taken_i.
im_ready_i  in  1  IM data valid for the address presented this cycle.
im_instr_i  in  32  IM read data.
im_req_o  out  1  IM access request; the IM address is pc_i.
pc_we_o  out  1  PC register write enable.
npc_o  out  32  next PC value.
f_valid_o  out  1  f_instr_o is valid for D to capture this cycle.
f_instr_o  out  32  instruction to D.
f_adel_o  out  1  fetch address error, qualified by f_valid_o.

Behaviour:
- States: IDLE, FETCH, HOLD. Registers: state, pend_v, pend_addr[31:0], buf_instr[31:0].
- Reset (reset==0, asynchronous): state=IDLE, pend_v=0, pend_addr=0, buf_instr=0.
- While in reset, all outputs are 0 except npc_o=RESET_PC.
- IDLE: all outputs 0. Transitions to FETCH next cycle.
- bad = pc_i[1:0]!=0 || pc_i<PC_LO || pc_i>PC_HI (unsigned compares).
- npc_o priority (combinational):
  - req_i -> EXC_ENTRY
  - else eret_i -> epc_i
  - else pend_v -> pend_addr
  - else br_taken_i -> br_target_i
  - else pc_i+4 (mod 2^32)
- Redirect (req_i or eret_i, any non-IDLE state): pc_we_o=1, f_valid_o=0, im_req_o=0, pend_v<=0, next state FETCH. An in-flight IM access is abandoned.
- FETCH, no redirect:
  - im_req_o = !bad.
  - done = bad || im_ready_i.
  - f_instr_o = bad ? 0 : im_instr_i.
  - f_adel_o = bad when f_valid_o.
  - done && !stall_i: f_valid_o=1, pc_we_o=1, stay FETCH; pend_v<=0 (the pend value is consumed via npc_o).
  - done && stall_i: f_valid_o=1, pc_we_o=0; buf_instr<=f_instr_o; next state HOLD. The registered adel is recomputed from the unchanged pc_i.
  - !done: f_valid_o=0, pc_we_o=0.
- Branch capture: if br_taken_i=1 and the cycle has pc_we_o=0 with no redirect, then pend_v<=1 and pend_addr<=br_target_i. This preserves the delay slot; the target is used at the next PC write. If pc_we_o=1 that cycle, br_target_i goes directly to npc_o and pend is not set.
- HOLD:
  - im_req_o=0, f_valid_o=1, f_instr_o=buf_instr, f_adel_o=bad.
  - stall_i=1: pc_we_o=0, stay HOLD.
  - stall_i=0: pc_we_o=1, pend_v<=0, next state FETCH.
- IM protocol: pc_i is stable while im_req_o=1 and pc_we_o=0. A PC change restarts the access.
- Reset asserted mid-fetch or in HOLD: immediate return to IDLE; the pending branch and buffer are discarded.

Test Plan:
- Reset release, im_ready_i held 1, stall 0 -> one IDLE cycle, then npc_o = 0x3004, 0x3008, 0x300c on successive cycles with pc_we_o=1 every cycle.
- IM with 3-cycle latency -> im_req_o high for 3 cycles at pc 0x3000; pc_we_o and f_valid_o pulse only in the cycle im_ready_i=1.
- br_taken_i pulse (target 0x3100) while the delay-slot fetch at 0x3008 waits on IM -> pend_v set; on ready, npc_o=0x3100, pc_we_o=1; the next cycle gives npc_o=0x3104.
- stall_i high for 2 cycles after instr 0x24010001 is fetched -> HOLD; f_instr_o=0x24010001 with f_valid_o=1 for those cycles; pc_we_o=0 until stall drops.
- req_i asserted during HOLD with pend_v=1 -> npc_o=0x4180, pc_we_o=1, f_valid_o=0; pend cleared. A following eret_i with epc_i=0x3010 -> npc_o=0x3010.
- pc_i=0x3002, and separately pc_i=0x7000 -> im_req_o=0, f_valid_o=1, f_instr_o=0, f_adel_o=1.
